// File: rtl/stream_mux_pkg.sv
// Shared types for the N:1 stream selector.
// Optional feature macro used by stream_mux_rr: MUX_PARITY_EN.
package stream_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin arbiter: masked priority encoder over requests above ptr,
// falling back to the lowest set request when nothing above ptr is pending.
module rr_arbiter #(
  parameter  int unsigned N_CH = 4,
  localparam int unsigned CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] gnt_idx,
  output logic            gnt_vld
);

  logic hit_masked;
  logic hit_any;

  // Pick the first request after ptr, wrapping to the lowest request.
  always_comb begin
    gnt_idx    = '0;
    hit_masked = 1'b0;
    hit_any    = 1'b0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (!hit_masked && req[k] && (k > 32'(ptr))) begin
        hit_masked = 1'b1;
        gnt_idx    = CH_W'(k);
      end
    end
    if (!hit_masked) begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        if (!hit_any && req[k]) begin
          hit_any = 1'b1;
          gnt_idx = CH_W'(k);
        end
      end
    end
    gnt_vld = |req;
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 stream selector with valid/ready handshake and one registered output
// stage. Fixed (sel-driven) or round-robin arbitration.
// Optional feature: define MUX_PARITY_EN to add the registered out_par port.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int unsigned N_CH   = 4,
  parameter  int unsigned DATA_W = 8,
  localparam int unsigned CH_W   = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [CH_W-1:0]          sel,
  input  logic [N_CH-1:0]          in_valid,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  output logic [N_CH-1:0]          in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_chan,
  input  logic                     out_ready,
  output logic                     sel_err
`ifdef MUX_PARITY_EN
  ,
  output logic                     out_par
`endif
);

  mode_e             mode_s;
  logic              load;
  logic              fixed_hit;
  logic              fixed_vld;
  logic [CH_W-1:0]   arb_idx;
  logic              arb_vld;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_vld;
  logic              xfer;
  logic [DATA_W-1:0] grant_data;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [CH_W-1:0]   out_chan_q,  out_chan_d;
  logic [CH_W-1:0]   rr_ptr_q,    rr_ptr_d;
  logic              sel_err_q,   sel_err_d;

  assign mode_s = mode_e'(mode);

  rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr_q),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  // Grant selection, handshake and next-state of the output register.
  always_comb begin
    load      = !out_valid_q | out_ready;
    fixed_hit = 1'b0;
    fixed_vld = 1'b0;
    // Decoding sel by comparison keeps out-of-range indices from
    // addressing past in_valid when N_CH is not a power of two.
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (sel == CH_W'(k)) begin
        fixed_hit = 1'b1;
        fixed_vld = in_valid[k];
      end
    end

    if (mode_s == MODE_RR) begin
      grant_idx = arb_idx;
      grant_vld = arb_vld;
    end else begin
      grant_idx = sel;
      grant_vld = fixed_vld;
    end

    in_ready   = '0;
    grant_data = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (grant_idx == CH_W'(k)) begin
        in_ready[k] = load & grant_vld;
        grant_data  = in_data[k*DATA_W +: DATA_W];
      end
    end
    xfer = load & grant_vld;

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_chan_d  = grant_idx;
      if (mode_s == MODE_RR) begin
        rr_ptr_d = grant_idx;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // An out-of-range sel can never produce a grant, so this fires only
    // when nothing is transferred.
    sel_err_d = (mode_s == MODE_FIXED) & !fixed_hit & (|in_valid);
  end

  // Output register, round-robin pointer and error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      rr_ptr_q    <= CH_W'(N_CH - 1);
      sel_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign sel_err   = sel_err_q;

`ifdef MUX_PARITY_EN
  logic out_par_q, out_par_d;

  // Parity of the held beat, captured alongside the data.
  always_comb begin
    out_par_d = out_par_q;
    if (xfer) begin
      out_par_d = ^grant_data;
    end
  end

  // Parity register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_par_q <= 1'b0;
    end else begin
      out_par_q <= out_par_d;
    end
  end

  assign out_par = out_par_q;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a 4-channel and a 3-channel instance.
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        mode4;
  logic [1:0]  sel4;
  logic [3:0]  in_valid4;
  logic [31:0] in_data4;
  logic [3:0]  in_ready4;
  logic        out_valid4;
  logic [7:0]  out_data4;
  logic [1:0]  out_chan4;
  logic        out_ready4;
  logic        sel_err4;

  logic        mode3;
  logic [1:0]  sel3;
  logic [2:0]  in_valid3;
  logic [23:0] in_data3;
  logic [2:0]  in_ready3;
  logic        out_valid3;
  logic [7:0]  out_data3;
  logic [1:0]  out_chan3;
  logic        out_ready3;
  logic        sel_err3;

`ifdef MUX_PARITY_EN
  logic        out_par4;
  logic        out_par3;
`endif

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.N_CH(4), .DATA_W(8)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode4),
    .sel       (sel4),
    .in_valid  (in_valid4),
    .in_data   (in_data4),
    .in_ready  (in_ready4),
    .out_valid (out_valid4),
    .out_data  (out_data4),
    .out_chan  (out_chan4),
    .out_ready (out_ready4),
    .sel_err   (sel_err4)
`ifdef MUX_PARITY_EN
    ,
    .out_par   (out_par4)
`endif
  );

  stream_mux_rr #(.N_CH(3), .DATA_W(8)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode3),
    .sel       (sel3),
    .in_valid  (in_valid3),
    .in_data   (in_data3),
    .in_ready  (in_ready3),
    .out_valid (out_valid3),
    .out_data  (out_data3),
    .out_chan  (out_chan3),
    .out_ready (out_ready3),
    .sel_err   (sel_err3)
`ifdef MUX_PARITY_EN
    ,
    .out_par   (out_par3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] rr_rdy [5];
    logic [1:0] rr_ch  [5];
    logic [7:0] rr_dat [5];
    rr_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_ch  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rr_dat = '{8'h11, 8'h22, 8'hA5, 8'h44, 8'h11};

    rst_n      = 1'b0;
    mode4      = 1'b0;
    sel4       = 2'd0;
    in_valid4  = 4'b0000;
    in_data4   = {8'h44, 8'hA5, 8'h22, 8'h11};
    out_ready4 = 1'b0;
    mode3      = 1'b0;
    sel3       = 2'd0;
    in_valid3  = 3'b000;
    in_data3   = {8'hC3, 8'hB2, 8'hA1};
    out_ready3 = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid4), 32'd0);
    chk("rst_out_data",  32'(out_data4),  32'h00);
    chk("rst_out_chan",  32'(out_chan4),  32'd0);
    chk("rst_sel_err",   32'(sel_err4),   32'd0);
    chk("rst_in_ready",  32'(in_ready4),  32'd0);
    chk("rst3_out_valid", 32'(out_valid3), 32'd0);
`ifdef MUX_PARITY_EN
    chk("rst_out_par",   32'(out_par4),   32'd0);
`endif
    rst_n = 1'b1;

    // Fixed mode, sel=2
    mode4      = 1'b0;
    sel4       = 2'd2;
    in_valid4  = 4'b0100;
    out_ready4 = 1'b1;
    #1;
    chk("fix_in_ready", 32'(in_ready4), 32'b0100);
    tick();
    chk("fix_out_valid", 32'(out_valid4), 32'd1);
    chk("fix_out_data",  32'(out_data4),  32'hA5);
    chk("fix_out_chan",  32'(out_chan4),  32'd2);
    in_valid4 = 4'b0000;
    tick();
    chk("drain_out_valid", 32'(out_valid4), 32'd0);
    chk("drain_out_data",  32'(out_data4),  32'hA5);
    chk("drain_out_chan",  32'(out_chan4),  32'd2);

    // Round-robin, all valid, full throughput
    mode4     = 1'b1;
    in_valid4 = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_in_ready", 32'(in_ready4), 32'(rr_rdy[i]));
      tick();
      chk("rr_out_valid", 32'(out_valid4), 32'd1);
      chk("rr_out_chan",  32'(out_chan4),  32'(rr_ch[i]));
      chk("rr_out_data",  32'(out_data4),  32'(rr_dat[i]));
    end

    // Backpressure holds ch0 beat
    out_ready4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready4), 32'd0);
      tick();
      chk("bp_out_valid", 32'(out_valid4), 32'd1);
      chk("bp_out_data",  32'(out_data4),  32'h11);
      chk("bp_out_chan",  32'(out_chan4),  32'd0);
    end
    out_ready4 = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready4), 32'b0010);
    tick();
    chk("bp_release_chan", 32'(out_chan4), 32'd1);
    chk("bp_release_data", 32'(out_data4), 32'h22);

    // Fixed grant does not move rr_ptr (still 1)
    mode4 = 1'b0;
    sel4  = 2'd3;
    #1;
    chk("mix_fix_in_ready", 32'(in_ready4), 32'b1000);
    tick();
    chk("mix_fix_chan", 32'(out_chan4), 32'd3);
    chk("mix_fix_data", 32'(out_data4), 32'h44);
    mode4 = 1'b1;
    #1;
    chk("mix_rr_in_ready", 32'(in_ready4), 32'b0100);
    tick();
    chk("mix_rr_chan", 32'(out_chan4), 32'd2);

    // Sparse requests with wrap (ptr=2)
    in_valid4 = 4'b1001;
    #1;
    chk("wrap_in_ready_a", 32'(in_ready4), 32'b1000);
    tick();
    chk("wrap_chan_a", 32'(out_chan4), 32'd3);
    #1;
    chk("wrap_in_ready_b", 32'(in_ready4), 32'b0001);
    tick();
    chk("wrap_chan_b", 32'(out_chan4), 32'd0);

    // Reset while holding a beat
    rst_n = 1'b0;
    tick();
    chk("midrst_out_valid", 32'(out_valid4), 32'd0);
    chk("midrst_out_data",  32'(out_data4),  32'h00);
    chk("midrst_out_chan",  32'(out_chan4),  32'd0);
    rst_n     = 1'b1;
    in_valid4 = 4'b1111;
    #1;
    chk("postrst_in_ready", 32'(in_ready4), 32'b0001);
    tick();
    chk("postrst_out_valid", 32'(out_valid4), 32'd1);
    chk("postrst_out_chan",  32'(out_chan4),  32'd0);
    in_valid4 = 4'b0000;
    tick();

    // N_CH=3: out-of-range sel
    mode3      = 1'b0;
    sel3       = 2'd3;
    in_valid3  = 3'b111;
    out_ready3 = 1'b1;
    #1;
    chk("n3_bad_in_ready", 32'(in_ready3), 32'd0);
    tick();
    chk("n3_sel_err",      32'(sel_err3),   32'd1);
    chk("n3_bad_out_valid", 32'(out_valid3), 32'd0);
    sel3 = 2'd1;
    #1;
    chk("n3_fix_in_ready", 32'(in_ready3), 32'b010);
    tick();
    chk("n3_sel_err_clr", 32'(sel_err3),   32'd0);
    chk("n3_out_valid",   32'(out_valid3), 32'd1);
    chk("n3_out_chan",    32'(out_chan3),  32'd1);
    chk("n3_out_data",    32'(out_data3),  32'hB2);
    mode3 = 1'b1;
    sel3  = 2'd3;
    #1;
    chk("n3_rr_in_ready", 32'(in_ready3), 32'b001);
    tick();
    chk("n3_rr_sel_err", 32'(sel_err3),  32'd0);
    chk("n3_rr_chan",    32'(out_chan3), 32'd0);
    chk("n3_rr_data",    32'(out_data3), 32'hA1);

`ifdef MUX_PARITY_EN
    // Parity of registered beat
    mode4     = 1'b0;
    sel4      = 2'd0;
    in_valid4 = 4'b0001;
    in_data4  = {8'h44, 8'hA5, 8'h22, 8'h07};
    tick();
    chk("par_data_07", 32'(out_data4), 32'h07);
    chk("par_07",      32'(out_par4),  32'd1);
    in_data4 = {8'h44, 8'hA5, 8'h22, 8'h03};
    tick();
    chk("par_data_03", 32'(out_data4), 32'h03);
    chk("par_03",      32'(out_par4),  32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
